// File: rtl/alu_op_controller.sv
// Issues one operation at a time to the arith/logic/compare/shift sub-units and holds the captured result.
// Build option ALU_OP_CONTROLLER_PERF_CNT_EN adds saturating op_count/err_count outputs.
module alu_op_controller #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned NUM_UNITS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          op_valid,
    output logic                          op_ready,
    input  logic [DATA_W-1:0]             op_a,
    input  logic [DATA_W-1:0]             op_b,
    input  logic [1:0]                    op_sel,
    input  logic [1:0]                    op_fn,
    output logic [DATA_W-1:0]             unit_a,
    output logic [DATA_W-1:0]             unit_b,
    output logic [1:0]                    unit_fn,
    output logic [NUM_UNITS-1:0]          unit_en,
    input  logic [NUM_UNITS*DATA_W-1:0]   unit_out,
    input  logic [NUM_UNITS-1:0]          unit_flag,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [DATA_W-1:0]             res_data,
    output logic                          res_err
`ifdef ALU_OP_CONTROLLER_PERF_CNT_EN
    ,
    output logic [15:0]                   op_count,
    output logic [7:0]                    err_count
`endif
);

    localparam int unsigned SEL_W = 2;
    localparam int unsigned FN_W  = 2;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t               state, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic                 op_ready_d, res_valid_d, res_err_d;
    logic [NUM_UNITS-1:0] unit_en_d;
    logic [DATA_W-1:0]    unit_a_d, unit_b_d, res_data_d, sel_slice;
    logic [FN_W-1:0]      unit_fn_d;
    logic                 accept, sel_flag;

    assign accept   = op_valid && op_ready;
    assign sel_flag = unit_flag[sel_q];

    // Result slice of the latched sub-unit; other units' outputs and flags are ignored.
    always_comb begin
        sel_slice = '0;
        for (int i = 0; i < int'(NUM_UNITS); i++) begin
            if (SEL_W'(i) == sel_q) sel_slice = unit_out[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (accept) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  state_d = S_DONE;
            S_DONE:  if (res_ready) state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; the enable pulse is launched on the accept edge.
    always_comb begin
        op_ready_d  = 1'b0;
        unit_en_d   = '0;
        res_valid_d = 1'b0;
        res_data_d  = res_data;
        res_err_d   = res_err;
        unit_a_d    = unit_a;
        unit_b_d    = unit_b;
        unit_fn_d   = unit_fn;
        sel_d       = sel_q;
        case (state)
            S_IDLE: begin
                op_ready_d = !accept;
                if (accept) begin
                    unit_a_d  = op_a;
                    unit_b_d  = op_b;
                    unit_fn_d = op_fn;
                    sel_d     = op_sel;
                    unit_en_d = NUM_UNITS'(1) << op_sel;
                end
            end
            S_ISSUE: ;
            S_WAIT: begin
                res_valid_d = 1'b1;
                res_data_d  = sel_flag ? sel_slice : '0;
                res_err_d   = !sel_flag;
            end
            S_DONE: begin
                res_valid_d = !res_ready;
                op_ready_d  = res_ready;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_ready  <= 1'b1;
            unit_en   <= '0;
            unit_a    <= '0;
            unit_b    <= '0;
            unit_fn   <= '0;
            sel_q     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_err   <= 1'b0;
        end else begin
            op_ready  <= op_ready_d;
            unit_en   <= unit_en_d;
            unit_a    <= unit_a_d;
            unit_b    <= unit_b_d;
            unit_fn   <= unit_fn_d;
            sel_q     <= sel_d;
            res_valid <= res_valid_d;
            res_data  <= res_data_d;
            res_err   <= res_err_d;
        end
    end

`ifdef ALU_OP_CONTROLLER_PERF_CNT_EN
    // Saturating completion and error counters, stepped on DONE->IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_count  <= '0;
            err_count <= '0;
        end else if (state == S_DONE && res_ready) begin
            if (op_count != 16'hFFFF) op_count <= op_count + 16'd1;
            if (res_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_controller.sv
// Directed self-checking bench for alu_op_controller with behavioural sub-unit models.
module tb_alu_op_controller;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_a, op_b;
    logic [1:0]  op_sel, op_fn;
    logic [15:0] unit_a, unit_b;
    logic [1:0]  unit_fn;
    logic [3:0]  unit_en;
    logic [63:0] unit_out;
    logic [3:0]  unit_flag;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_err;
`ifdef ALU_OP_CONTROLLER_PERF_CNT_EN
    logic [15:0] op_count;
    logic [7:0]  err_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0][15:0] model_out;
    logic [3:0]       model_flag;
    logic             logic_flag_dis = 1'b0;
    logic [3:0]       stray_mask = 4'b0000;

    alu_op_controller dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sel    (op_sel),
        .op_fn     (op_fn),
        .unit_a    (unit_a),
        .unit_b    (unit_b),
        .unit_fn   (unit_fn),
        .unit_en   (unit_en),
        .unit_out  (unit_out),
        .unit_flag (unit_flag),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err)
`ifdef ALU_OP_CONTROLLER_PERF_CNT_EN
        ,
        .op_count  (op_count),
        .err_count (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] calc(input int u, input logic [15:0] a, input logic [15:0] b,
                                         input logic [1:0] fn);
        logic [15:0] r;
        r = '0;
        case (u)
            0: case (fn)
                2'd0: r = a + b;
                2'd1: r = a - b;
                2'd2: r = a + 16'd1;
                default: r = 16'd0 - a;
            endcase
            1: case (fn)
                2'd0: r = a & b;
                2'd1: r = a | b;
                2'd2: r = a ^ b;
                default: r = ~a;
            endcase
            2: case (fn)
                2'd0: r = {15'd0, a == b};
                2'd1: r = {15'd0, $signed(a) < $signed(b)};
                2'd2: r = {15'd0, a < b};
                default: r = {15'd0, $signed(a) > $signed(b)};
            endcase
            default: case (fn)
                2'd0: r = a >> 1;
                2'd1: r = a << 1;
                2'd2: r = 16'($signed(a) >>> 1);
                default: r = a << b[3:0];
            endcase
        endcase
        return r;
    endfunction

    // Sub-units: result and flag live for exactly one cycle after an enabled edge.
    assign unit_out  = model_out;
    assign unit_flag = model_flag | stray_mask;
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (unit_en[i]) begin
                model_out[i]  <= calc(i, unit_a, unit_b, unit_fn);
                model_flag[i] <= !(i == 1 && logic_flag_dis);
            end else begin
                model_out[i]  <= 16'h0000;
                model_flag[i] <= 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; op_valid = 1'b0; op_a = '0; op_b = '0; op_sel = '0; op_fn = '0; res_ready = 1'b0;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL rst_op_ready: got %b want 1", op_ready); end
        n_checks++; if (unit_en !== 4'b0000) begin n_fail++; $display("FAIL rst_unit_en: got %b want 0000", unit_en); end
        n_checks++; if (unit_a !== 16'h0000) begin n_fail++; $display("FAIL rst_unit_a: got %h want 0000", unit_a); end
        n_checks++; if (unit_b !== 16'h0000) begin n_fail++; $display("FAIL rst_unit_b: got %h want 0000", unit_b); end
        n_checks++; if (unit_fn !== 2'b00) begin n_fail++; $display("FAIL rst_unit_fn: got %b want 00", unit_fn); end
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
        n_checks++; if (res_data !== 16'h0000) begin n_fail++; $display("FAIL rst_res_data: got %h want 0000", res_data); end
        n_checks++; if (res_err !== 1'b0) begin n_fail++; $display("FAIL rst_res_err: got %b want 0", res_err); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_shift();
        op_a = 16'h0004; op_b = 16'h0000; op_sel = 2'd3; op_fn = 2'b00; res_ready = 1'b1; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        n_checks++; if (unit_en !== 4'b1000) begin n_fail++; $display("FAIL shift_en_c1: got %b want 1000", unit_en); end
        n_checks++; if (op_ready !== 1'b0) begin n_fail++; $display("FAIL shift_ready_c1: got %b want 0", op_ready); end
        n_checks++; if (unit_a !== 16'h0004) begin n_fail++; $display("FAIL shift_unit_a: got %h want 0004", unit_a); end
        step();
        n_checks++; if (unit_en !== 4'b0000) begin n_fail++; $display("FAIL shift_en_c2: got %b want 0000", unit_en); end
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL shift_valid_c2: got %b want 0", res_valid); end
        step();
        n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL shift_valid_c3: got %b want 1", res_valid); end
        n_checks++; if (res_data !== 16'h0002) begin n_fail++; $display("FAIL shift_data: got %h want 0002", res_data); end
        n_checks++; if (res_err !== 1'b0) begin n_fail++; $display("FAIL shift_err: got %b want 0", res_err); end
        step();
        n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL shift_ready_c4: got %b want 1", op_ready); end
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL shift_valid_c4: got %b want 0", res_valid); end
        n_checks++; if (unit_a !== 16'h0004) begin n_fail++; $display("FAIL shift_a_hold: got %h want 0004", unit_a); end
    endtask

    task automatic test_backpressure();
        op_a = 16'h8001; op_b = 16'h0000; op_sel = 2'd3; op_fn = 2'b01; res_ready = 1'b0; op_valid = 1'b1;
        step();
        op_a = 16'h0003; op_b = 16'h0005; op_sel = 2'd0; op_fn = 2'b00;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", i, res_valid); end
            n_checks++; if (res_data !== 16'h0002) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want 0002", i, res_data); end
            n_checks++; if (op_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0", i, op_ready); end
            n_checks++; if (unit_en !== 4'b0000) begin n_fail++; $display("FAIL bp_en[%0d]: got %b want 0000", i, unit_en); end
            if (i < 4) step();
        end
        res_ready = 1'b1;
        step();
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", res_valid); end
        n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", op_ready); end
        n_checks++; if (unit_en !== 4'b0000) begin n_fail++; $display("FAIL bp_early_accept: got %b want 0000", unit_en); end
        step();
        op_valid = 1'b0;
        n_checks++; if (unit_en !== 4'b0001) begin n_fail++; $display("FAIL bp_second_en: got %b want 0001", unit_en); end
        step();
        step();
        n_checks++; if (res_data !== 16'h0008) begin n_fail++; $display("FAIL bp_second_data: got %h want 0008", res_data); end
        step();
    endtask

    task automatic test_missing_flag();
        logic_flag_dis = 1'b1; stray_mask = 4'b0100;
        op_a = 16'hFFFF; op_b = 16'h00FF; op_sel = 2'd1; op_fn = 2'b00; res_ready = 1'b1; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        n_checks++; if (unit_en !== 4'b0010) begin n_fail++; $display("FAIL mf_en: got %b want 0010", unit_en); end
        step();
        step();
        n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL mf_valid: got %b want 1", res_valid); end
        n_checks++; if (res_err !== 1'b1) begin n_fail++; $display("FAIL mf_err: got %b want 1", res_err); end
        n_checks++; if (res_data !== 16'h0000) begin n_fail++; $display("FAIL mf_data: got %h want 0000", res_data); end
        step();
        logic_flag_dis = 1'b0; stray_mask = 4'b1110;
        op_a = 16'h0005; op_b = 16'h0007; op_sel = 2'd0; op_fn = 2'b01; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        step();
        step();
        n_checks++; if (res_err !== 1'b0) begin n_fail++; $display("FAIL stray_err: got %b want 0", res_err); end
        n_checks++; if (res_data !== 16'hFFFE) begin n_fail++; $display("FAIL stray_data: got %h want fffe", res_data); end
        step();
        stray_mask = 4'b0000;
    endtask

    task automatic test_back_to_back();
        logic [15:0] va[3], vb[3], ve[3];
        logic [1:0]  vs[3], vf[3];
        int issued, got, last_cyc;
        va[0] = 16'h1234; vb[0] = 16'h0111; vs[0] = 2'd0; vf[0] = 2'd0; ve[0] = 16'h1345;
        va[1] = 16'hF0F0; vb[1] = 16'h0FF0; vs[1] = 2'd1; vf[1] = 2'd2; ve[1] = 16'hFF00;
        va[2] = 16'hFFFF; vb[2] = 16'h0001; vs[2] = 2'd2; vf[2] = 2'd1; ve[2] = 16'h0001;
        issued = 0; got = 0; last_cyc = 0;
        res_ready = 1'b1;
        op_a = va[0]; op_b = vb[0]; op_sel = vs[0]; op_fn = vf[0]; op_valid = 1'b1;
        for (int cyc = 1; cyc <= 30 && got < 3; cyc++) begin
            step();
            n_checks++; if ($countones(unit_en) > 1) begin n_fail++; $display("FAIL b2b_multihot: got %b at cycle %0d", unit_en, cyc); end
            if (unit_en != 4'b0000 && issued < 3) begin
                n_checks++;
                if (unit_en !== (4'b0001 << vs[issued])) begin
                    n_fail++; $display("FAIL b2b_en[%0d]: got %b want %b", issued, unit_en, 4'b0001 << vs[issued]);
                end
                issued++;
                if (issued < 3) begin
                    op_a = va[issued]; op_b = vb[issued]; op_sel = vs[issued]; op_fn = vf[issued];
                end else begin
                    op_valid = 1'b0;
                end
            end
            if (res_valid && got < 3) begin
                n_checks++; if (res_data !== ve[got]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", got, res_data, ve[got]); end
                if (got > 0) begin
                    n_checks++; if (cyc - last_cyc != 4) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d want 4", got, cyc - last_cyc); end
                end
                last_cyc = cyc;
                got++;
            end
        end
        op_valid = 1'b0;
        n_checks++; if (got != 3) begin n_fail++; $display("FAIL b2b_timeout: got %0d results want 3", got); end
        step();
    endtask

    task automatic test_reset_mid_op();
        op_a = 16'h0001; op_b = 16'h0001; op_sel = 2'd0; op_fn = 2'b00; res_ready = 1'b1; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        step();
        rst = 1'b0;
        #1;
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", res_valid); end
        n_checks++; if (unit_en !== 4'b0000) begin n_fail++; $display("FAIL rmid_en: got %b want 0000", unit_en); end
        n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b want 1", op_ready); end
        step();
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_held_valid: got %b want 0", res_valid); end
        rst = 1'b1;
        op_a = 16'h0002; op_b = 16'h0003; op_sel = 2'd0; op_fn = 2'b00; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        n_checks++; if (unit_en !== 4'b0001) begin n_fail++; $display("FAIL rmid_new_en: got %b want 0001", unit_en); end
        step();
        step();
        n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_new_valid: got %b want 1", res_valid); end
        n_checks++; if (res_data !== 16'h0005) begin n_fail++; $display("FAIL rmid_new_data: got %h want 0005", res_data); end
        step();
    endtask

`ifdef ALU_OP_CONTROLLER_PERF_CNT_EN
    task automatic test_perf_counters();
        rst = 1'b0;
        #1 rst = 1'b1;
        res_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            logic_flag_dis = (k == 2);
            op_a = 16'h0010; op_b = 16'h0001; op_sel = (k == 2) ? 2'd1 : 2'd0; op_fn = 2'b00; op_valid = 1'b1;
            step();
            op_valid = 1'b0;
            step();
            step();
            step();
        end
        logic_flag_dis = 1'b0;
        n_checks++; if (op_count !== 16'd5) begin n_fail++; $display("FAIL perf_op_count: got %0d want 5", op_count); end
        n_checks++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL perf_err_count: got %0d want 1", err_count); end
        force dut.op_count = 16'hFFFF;
        #1;
        release dut.op_count;
        op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        step();
        step();
        step();
        n_checks++; if (op_count !== 16'hFFFF) begin n_fail++; $display("FAIL perf_op_sat: got %h want ffff", op_count); end
        n_checks++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL perf_err_hold: got %0d want 1", err_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_shift();
        test_backpressure();
        test_missing_flag();
        test_back_to_back();
        test_reset_mid_op();
`ifdef ALU_OP_CONTROLLER_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
